// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with 2-bit saturating counters
module branch_target_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int IMM_WIDTH  = 16,
    parameter int ENTRIES    = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  predict_valid,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_target,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic [IMM_WIDTH-1:0]  update_immediate,
    input  logic                  update_taken,
    input  logic                  flush
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;
    localparam int EXT_W = ADDR_WIDTH - IMM_WIDTH;

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];

    logic [IDX-1:0]        lk_idx, up_idx;
    logic [TAG_W-1:0]      lk_tag, up_tag;
    logic                  lk_hit, up_hit;
    logic [ADDR_WIDTH-1:0] imm_ext, up_target;
    logic [1:0]            ctr_cur, ctr_next;

    assign lk_idx = lookup_pc[IDX+1:2];
    assign lk_tag = lookup_pc[ADDR_WIDTH-1:IDX+2];
    assign up_idx = update_pc[IDX+1:2];
    assign up_tag = update_pc[ADDR_WIDTH-1:IDX+2];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Word-aligned branch offset relative to the following instruction; wraps silently.
    assign imm_ext   = {{EXT_W{update_immediate[IMM_WIDTH-1]}}, update_immediate};
    assign up_target = update_pc + ADDR_WIDTH'(4) + {imm_ext[ADDR_WIDTH-3:0], 2'b00};

    assign ctr_cur = ctr_q[up_idx];

    always_comb begin
        ctr_next = ctr_cur;
        if (update_taken) begin
            if (ctr_cur != 2'd3) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'd0) ctr_next = ctr_cur - 2'd1;
        end
    end

    // Only valid bits are reset; the rest of the entry is qualified by valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (update_valid && !up_hit && update_taken) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (update_valid && !flush) begin
            if (up_hit) begin
                ctr_q[up_idx]    <= ctr_next;
                target_q[up_idx] <= up_target;
            end else if (update_taken) begin
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= up_target;
                ctr_q[up_idx]    <= 2'd2;
            end
        end
    end

    // Response reads pre-update, pre-flush contents of this cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            predict_valid  <= 1'b0;
            predict_taken  <= 1'b0;
            predict_target <= '0;
        end else begin
            predict_valid <= lookup_valid;
            if (lookup_valid && lk_hit && ctr_q[lk_idx][1]) begin
                predict_taken  <= 1'b1;
                predict_target <= target_q[lk_idx];
            end else begin
                predict_taken  <= 1'b0;
                predict_target <= '0;
            end
        end
    end
endmodule
